// File: rtl/mem_copy_engine.sv
// Word-by-word memory copy engine: alternates a read cycle and a write cycle per word
// against a single-port memory with combinational read data.
module mem_copy_engine #(
   parameter int DEPTH = 120
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] src_addr,
   input  logic [7:0] dst_addr,
   input  logic [7:0] len,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [7:0] mem_addr,
   output logic       mem_wr_en,
   output logic [7:0] mem_din,
   input  logic [7:0] mem_dout
);

   localparam logic [8:0] DEPTH_LIM = 9'(DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t     state, state_nxt;
   logic [7:0] src_q, dst_q, len_q, idx_q, hold_q;
   logic       err_q;
   logic       req_err;

   // Sums are widened to 9 bits so a window running past address 255 still flags.
   function automatic logic range_err(input logic [7:0] base, input logic [7:0] n);
      return ({1'b0, base} + {1'b0, n}) > DEPTH_LIM;
   endfunction

   always_comb begin
      req_err = range_err(src_addr, len) | range_err(dst_addr, len);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         src_q  <= '0;
         dst_q  <= '0;
         len_q  <= '0;
         idx_q  <= '0;
         hold_q <= '0;
         err_q  <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (start) begin
                  src_q <= src_addr;
                  dst_q <= dst_addr;
                  len_q <= len;
                  idx_q <= '0;
                  err_q <= req_err;
               end
            end
            RD:      hold_q <= mem_dout;
            WR:      idx_q  <= idx_q + 8'd1;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b1;
      done      = 1'b0;
      mem_addr  = '0;
      mem_wr_en = 1'b0;
      mem_din   = '0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_nxt = (req_err || len == 8'd0) ? DONE : RD;
            end
         end
         RD: begin
            mem_addr  = src_q + idx_q;
            state_nxt = WR;
         end
         WR: begin
            mem_addr  = dst_q + idx_q;
            mem_wr_en = 1'b1;
            mem_din   = hold_q;
            state_nxt = (idx_q + 8'd1 == len_q) ? DONE : RD;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign err = err_q;

endmodule

// File: doc/mem_copy_engine.md
MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 The block SHALL have parameter DEPTH, default 120, giving the number of valid data-memory words (addresses 0..DEPTH-1).
REQ-002 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request pulse; sampled only in IDLE.
REQ-006 src_addr  input  8  first source word address.
REQ-007 dst_addr  input  8  first destination word address.
REQ-008 len  input  8  number of words to copy (0..255).
REQ-009 busy  output  1  high from the cycle after an accepted start through the DONE cycle inclusive.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 err  output  1  range error for the last accepted request; held until the next accepted start.
REQ-012 mem_addr  output  8  address to the data memory.
REQ-013 mem_wr_en  output  1  write enable to the data memory.
REQ-014 mem_din  output  8  write data to the data memory.
REQ-015 mem_dout  input  8  read data from the data memory; combinational on mem_addr, no read latency.

Function
REQ-016 The FSM SHALL have states IDLE, RD, WR and DONE.
REQ-017 IDLE: start=1 accepts the request and latches src_addr, dst_addr and len; the index counter clears to 0 and err is updated.
REQ-018 Range check at accept, 9-bit arithmetic: err=1 if src_addr+len > DEPTH or dst_addr+len > DEPTH; otherwise err=0.
REQ-019 From IDLE on accept: if err=1 or len=0, go to DONE; otherwise go to RD.
REQ-020 RD: mem_addr=src+idx (8-bit); mem_wr_en=0; mem_dout captured into hold register at cycle end; next state WR.
REQ-021 WR: mem_addr=dst+idx; mem_wr_en=1; mem_din=hold; idx increments at cycle end.
REQ-022 From WR: next state DONE if idx+1 == len, else RD.
REQ-023 DONE: done=1 for exactly that one cycle; no memory write; next state IDLE.
REQ-024 Latency: for a valid len=N>0, done SHALL be high in the cycle 2N+1 cycles after the start-accept cycle; for len=0 or err=1, in the cycle immediately after accept.
REQ-025 Each word SHALL be written exactly once, in ascending index order; an overlapping copy with src < dst < src+len propagates already-copied data (defined behaviour, not an error).
REQ-026 An err=1 request SHALL perform no memory reads and no memory writes.
REQ-027 start SHALL be ignored in RD, WR and DONE; no queuing.
REQ-028 In IDLE and DONE: mem_addr=0, mem_wr_en=0, mem_din=0.
REQ-029 mem_wr_en SHALL be high only in WR and SHALL never be high in two consecutive cycles.

Reset
REQ-030 reset=1 at a rising edge SHALL force IDLE, idx=0, hold=0, busy=0, done=0, err=0, mem_addr=0, mem_wr_en=0 and mem_din=0, overriding start.
REQ-031 Reset during RD or WR SHALL abort the copy with no further writes after the reset edge; words already written remain, and no done pulse is issued.

Verification
REQ-032 Basic copy: memory[10..13]=A1,B2,C3,D4; start with src=10, dst=50, len=4 -> mem[50..53]=A1,B2,C3,D4, done exactly 9 cycles after accept, err=0, exactly 4 write cycles.
REQ-033 Zero length: start with len=0 -> done the next cycle, err=0, no mem_wr_en pulse.
REQ-034 Range error: src=118, dst=0, len=3 (DEPTH=120) -> err=1, done the next cycle, no writes; err holds until the next accepted start. Boundary case src=117, len=3 -> accepted, err=0.
REQ-035 Overlap: mem[20..22]=01,02,03; src=20, dst=21, len=2 -> mem[21]=01, mem[22]=01.
REQ-036 Start while busy: a second start during a len=4 copy -> ignored, exactly one done pulse, no extra writes.
REQ-037 Mid-copy reset: reset asserted in the second WR of a len=4 copy -> mem_wr_en=0 from the next cycle, exactly 2 destination words written, busy=0, no done pulse, and a new start afterwards is accepted normally.
